// File: rtl/fpu_round_pipe.sv
// -----------------------------------------------------------------------------
// fpu_round_pipe
//
// Two-stage pipelined rounding and packing unit. Accepts an unrounded result
// (sign, special-case flags, biased exponent, mantissa with hidden bit, three
// guard bits and a rounding mode). It produces a packed IEEE-754 word plus
// {overflow, underflow, inexact} flags. The same RTL is instantiated for single
// precision (EXP_W=8, MAN_W=23) and double precision (EXP_W=11, MAN_W=52).
//
// Stage 1 registers the rounding decision (increment, inexact, tiny, overflow
// hint, special class). Stage 2 applies the increment, renormalises and packs.
// Both stages use a valid/ready handshake with full backpressure. A stalled
// stage holds its contents, so the outputs are stable while
// out_valid & !out_ready.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   input handshake (in_ready does not depend on in_valid)
//   in_sign, in_nan, in_inf, in_zero   sign and special-case flags
//   in_exponent [EXP_W]   biased exponent
//   in_mantissa [MAN_W+1] mantissa, MSB = hidden bit (0 means denormal)
//   in_guard [3]          {round bit, second guard bit, sticky}
//   in_mode [2]           0=EVEN, 1=DOWN, 2=UP, 3=ZERO
//   in_tag [TAG_W]        opaque tag carried alongside the beat
//   out_valid / out_ready output handshake
//   out_result            packed {sign, exponent, mantissa}
//   out_flags [3]         {overflow, underflow, inexact}
//   out_tag [TAG_W]       tag of the output beat
// -----------------------------------------------------------------------------
module fpu_round_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_sign,
    input  logic                     in_nan,
    input  logic                     in_inf,
    input  logic                     in_zero,
    input  logic [EXP_W-1:0]         in_exponent,
    input  logic [MAN_W:0]           in_mantissa,
    input  logic [2:0]               in_guard,
    input  logic [1:0]               in_mode,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MAN_W:0]     out_result,
    output logic [2:0]               out_flags,
    output logic [TAG_W-1:0]         out_tag
);

    localparam int W = EXP_W + MAN_W + 1;

    localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};
    // Largest finite biased exponent (all-ones minus one).
    localparam logic [EXP_W-1:0] EXP_MAXF = {{(EXP_W-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {
        CLS_NUM  = 2'd0,
        CLS_ZERO = 2'd1,
        CLS_INF  = 2'd2,
        CLS_NAN  = 2'd3
    } cls_t;

    // -------------------------------------------------------------------------
    // Handshake / advance control
    // -------------------------------------------------------------------------
    logic s1_valid_reg;
    logic s2_valid_reg;
    logic s1_adv;
    logic s2_adv;

    assign s2_adv   = !s2_valid_reg || out_ready;
    assign s1_adv   = !s1_valid_reg || s2_adv;
    assign in_ready = s1_adv;

    // -------------------------------------------------------------------------
    // Stage 1: rounding decision
    // -------------------------------------------------------------------------
    logic r_bit;
    logic s_bit;
    logic l_bit;
    logic [3:0] inc_by_mode;

    assign r_bit = in_guard[2];
    assign s_bit = in_guard[1] | in_guard[0];
    assign l_bit = in_mantissa[0];

    // One increment rule per rounding mode. The beat's own mode then selects
    // one of them, so mixed-mode beats can stream back to back.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_inc
            if (gi == 0) begin : g_even
                assign inc_by_mode[gi] = r_bit & (s_bit | l_bit);
            end else if (gi == 1) begin : g_down
                assign inc_by_mode[gi] = in_sign & (r_bit | s_bit);
            end else if (gi == 2) begin : g_up
                assign inc_by_mode[gi] = !in_sign & (r_bit | s_bit);
            end else begin : g_zero
                assign inc_by_mode[gi] = 1'b0;
            end
        end
    endgenerate

    cls_t s1_cls_next;
    logic s1_inexact_next;
    logic s1_tiny_next;
    logic s1_ovf_next;

    always_comb begin
        s1_cls_next = CLS_NUM;
        if (in_nan) begin
            s1_cls_next = CLS_NAN;
        end else if (in_inf) begin
            s1_cls_next = CLS_INF;
        end else if (in_zero) begin
            s1_cls_next = CLS_ZERO;
        end
    end

    assign s1_inexact_next = r_bit | s_bit;
    assign s1_tiny_next    = (in_exponent == '0) && s1_inexact_next;

    // Overflow is judged on the nearest-rounded magnitude: an all-ones input
    // exponent, or a mantissa of all ones at the largest finite exponent with
    // the round bit set, lies at or beyond the halfway point above max finite.
    // The delivered value still follows the mode. Directed modes that do not
    // increment therefore still flag overflow while returning max finite.
    assign s1_ovf_next = (in_exponent == EXP_ONES) ||
                         ((in_exponent == EXP_MAXF) && (&in_mantissa) && r_bit);

    cls_t               s1_cls_reg;
    logic               s1_sign_reg;
    logic [EXP_W-1:0]   s1_exp_reg;
    logic [MAN_W:0]     s1_man_reg;
    logic               s1_inc_reg;
    logic               s1_inexact_reg;
    logic               s1_tiny_reg;
    logic               s1_ovf_reg;
    logic [1:0]         s1_mode_reg;
    logic [TAG_W-1:0]   s1_tag_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg   <= 1'b0;
            s1_cls_reg     <= CLS_NUM;
            s1_sign_reg    <= 1'b0;
            s1_exp_reg     <= '0;
            s1_man_reg     <= '0;
            s1_inc_reg     <= 1'b0;
            s1_inexact_reg <= 1'b0;
            s1_tiny_reg    <= 1'b0;
            s1_ovf_reg     <= 1'b0;
            s1_mode_reg    <= '0;
            s1_tag_reg     <= '0;
        end else if (s1_adv) begin
            s1_valid_reg <= in_valid;
            if (in_valid) begin
                s1_cls_reg     <= s1_cls_next;
                s1_sign_reg    <= in_sign;
                s1_exp_reg     <= in_exponent;
                s1_man_reg     <= in_mantissa;
                s1_inc_reg     <= inc_by_mode[in_mode];
                s1_inexact_reg <= s1_inexact_next;
                s1_tiny_reg    <= s1_tiny_next;
                s1_ovf_reg     <= s1_ovf_next;
                s1_mode_reg    <= in_mode;
                s1_tag_reg     <= in_tag;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stage 2: apply increment, renormalise, pack
    // -------------------------------------------------------------------------
    logic [MAN_W+1:0] man_sum;
    logic             man_carry;
    logic [MAN_W:0]   man_rnd;
    logic [EXP_W:0]   exp_rnd;
    logic             ovf;
    logic [3:0]       ovf_inf_by_mode;
    logic             ovf_to_inf;

    assign man_sum   = {1'b0, s1_man_reg} + {{(MAN_W+1){1'b0}}, s1_inc_reg};
    assign man_carry = man_sum[MAN_W+1];
    assign man_rnd   = man_carry ? man_sum[MAN_W+1:1] : man_sum[MAN_W:0];

    // The exponent is one bit wider so a carry out of the largest exponent is
    // visible. A denormal whose rounded hidden bit comes out set becomes the
    // smallest normal (exponent 1).
    always_comb begin
        exp_rnd = {1'b0, s1_exp_reg} + {{EXP_W{1'b0}}, man_carry};
        if ((s1_exp_reg == '0) && !man_carry && man_rnd[MAN_W]) begin
            exp_rnd = {{EXP_W{1'b0}}, 1'b1};
        end
    end

    assign ovf = s1_ovf_reg || (exp_rnd >= {1'b0, EXP_ONES});

    // Per-mode overflow target: 1 = signed infinity, 0 = signed max finite.
    generate
        for (gi = 0; gi < 4; gi++) begin : g_ovf
            if (gi == 0) begin : g_even
                assign ovf_inf_by_mode[gi] = 1'b1;
            end else if (gi == 1) begin : g_down
                assign ovf_inf_by_mode[gi] = s1_sign_reg;
            end else if (gi == 2) begin : g_up
                assign ovf_inf_by_mode[gi] = !s1_sign_reg;
            end else begin : g_zero
                assign ovf_inf_by_mode[gi] = 1'b0;
            end
        end
    endgenerate

    assign ovf_to_inf = ovf_inf_by_mode[s1_mode_reg];

    logic [W-1:0] result_next;
    logic [2:0]   flags_next;

    always_comb begin
        result_next = '0;
        flags_next  = '0;
        case (s1_cls_reg)
            CLS_NAN: begin
                result_next = '1;
            end
            CLS_INF: begin
                result_next = {s1_sign_reg, EXP_ONES, {MAN_W{1'b0}}};
            end
            CLS_ZERO: begin
                result_next = {s1_sign_reg, {(W-1){1'b0}}};
            end
            default: begin
                if (ovf) begin
                    flags_next = {1'b1, s1_tiny_reg, 1'b1};
                    if (ovf_to_inf) begin
                        result_next = {s1_sign_reg, EXP_ONES, {MAN_W{1'b0}}};
                    end else begin
                        result_next = {s1_sign_reg, EXP_MAXF, {MAN_W{1'b1}}};
                    end
                end else begin
                    flags_next  = {1'b0, s1_tiny_reg, s1_inexact_reg};
                    result_next = {s1_sign_reg, exp_rnd[EXP_W-1:0], man_rnd[MAN_W-1:0]};
                end
            end
        endcase
    end

    logic [W-1:0]     out_result_reg;
    logic [2:0]       out_flags_reg;
    logic [TAG_W-1:0] out_tag_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_reg   <= 1'b0;
            out_result_reg <= '0;
            out_flags_reg  <= '0;
            out_tag_reg    <= '0;
        end else if (s2_adv) begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                out_result_reg <= result_next;
                out_flags_reg  <= flags_next;
                out_tag_reg    <= s1_tag_reg;
            end
        end
    end

    assign out_valid  = s2_valid_reg;
    assign out_result = out_result_reg;
    assign out_flags  = out_flags_reg;
    assign out_tag    = out_tag_reg;

endmodule

// File: doc/fpu_round_pipe.md
Name: fpu_round_pipe

Overview:
- Parametrised, two-stage pipelined rounding and packing unit for the FPU.
- Takes an unrounded result from the add, mult, div or sqrt datapaths: sign, special flags, biased exponent, mantissa with hidden bit, guard and sticky bits, and rounding mode.
- Emits a packed IEEE-754 word plus exception flags.
- One instance serves single precision (8/23) and another double precision (11/52). Valid/ready handshake with full backpressure.

Parameters:
- EXP_W, 8, exponent field width (11 for double).
- MAN_W, 23, stored mantissa width, hidden bit excluded (52 for double).
- TAG_W, 4, width of the opaque tag carried alongside each result.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  unit can accept a beat this cycle.
- in_sign  in  1  result sign.
- in_nan  in  1  result is NaN.
- in_inf  in  1  result is infinity.
- in_zero  in  1  result is zero.
- in_exponent  in  EXP_W  biased exponent.
- in_mantissa  in  MAN_W+1  mantissa; MSB is the hidden bit (0 means denormal).
- in_guard  in  3  {round bit, second guard bit, sticky}.
- in_mode  in  2  0=EVEN, 1=DOWN, 2=UP, 3=ZERO.
- in_tag  in  TAG_W  passthrough tag.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_result  out  EXP_W+MAN_W+1  packed {sign, exponent, mantissa}.
- out_flags  out  3  {overflow, underflow, inexact}.
- out_tag  out  TAG_W  tag of the output beat.

Behaviour:
- Reset (async assert, deasserted synchronously by the integrator):
  - Both stage valids clear, so out_valid=0.
  - out_result=0, out_flags=0, out_tag=0.
  - in_ready=1 while out_valid=0.
- Pipeline: S1 register, then S2 register (drives outputs).
  - Latency is exactly 2 cycles from accepted input to out_valid when out_ready=1.
  - Throughput is 1 beat per cycle.
- Advance rules:
  - s2_adv = !s2_valid | out_ready.
  - s1_adv = !s1_valid | s2_adv.
  - in_ready = s1_adv (combinational, no dependency on in_valid).
- Held stage: a stage that does not advance holds its data unchanged. out_result, out_flags and out_tag are stable while out_valid & !out_ready.
- Beat ordering is strictly preserved; no beat is dropped or duplicated.
- S1 (round decision):
  - R = guard[2]; S = guard[1] | guard[0]; L = mantissa[0].
  - inc: EVEN gives R&(S|L); DOWN gives sign&(R|S); UP gives !sign&(R|S); ZERO gives 0.
  - inexact = R|S.
  - tiny = (exponent==0) & inexact.
  - The special-case class is registered with the beat.
- S2 (apply):
  - m = mantissa + inc, computed MAN_W+2 wide.
  - Carry out of the MSB: mantissa shifts right by 1 and exponent increments.
  - Exponent 0 with the rounded hidden bit set: exponent becomes 1 (denormal rounds up to the smallest normal).
- Overflow (exponent reaches all-ones after rounding, or input exponent all-ones with no special flag):
  - overflow=1, inexact=1.
  - EVEN: signed infinity.
  - ZERO: max finite (exponent all-ones minus 1, mantissa all-ones).
  - DOWN: +max finite for positive, -inf for negative.
  - UP: +inf for positive, -max finite for negative.
- underflow = tiny.
- Special-case priority is nan > inf > zero, and each clears all flags:
  - NaN: all-ones word.
  - Inf: sign, exponent all-ones, mantissa 0.
  - Zero: sign, all other bits 0.
  - Guard bits are ignored for specials.
- in_mode is sampled per beat, so mixed modes stream back-to-back.
- Reset mid-operation: all in-flight beats are discarded. No beat from before reset appears after rst_n deasserts.

Test Plan:
- Single precision, EVEN, exp 0x7F, mantissa 0x800001, guard 3'b100 -> 0x3F800002, flags 3'b001, two cycles later. The same beat with mantissa 0x800000 -> 0x3F800000, flags 3'b001.
- Mantissa carry: exp 0x7F, mantissa 0xFFFFFF, guard 3'b110, EVEN -> 0x40000000, inexact=1.
- Overflow: exp 0xFE, mantissa 0xFFFFFF, guard 3'b100, sign 0:
  - EVEN -> 0x7F800000, flags 3'b101.
  - ZERO -> 0x7F7FFFFF, flags 3'b101.
  - Sign 1 with UP -> 0xFF7FFFFF.
- Specials: in_nan=1 with guard 3'b111 -> 0xFFFFFFFF, flags 0. Denormal: exp 0, mantissa 0x7FFFFF, guard 3'b100, EVEN -> 0x00800000, flags 3'b011.
- Backpressure: stream tags 1..4 on consecutive cycles with out_ready=0 for cycles 2-5.
  - in_ready drops once both stages are full.
  - Tags exit in order 1,2,3,4 with data stable while stalled.
- Reset mid-flight and double precision:
  - Pull rst_n low with both stages valid -> out_valid=0 immediately, no output after release.
  - EXP_W=11, MAN_W=52, exp 0x3FF, mantissa {1, 52'h0}, guard 0 -> 0x3FF0000000000000, flags 0.
